// File: rtl/dgldpc_pkg.sv
// Shared widths, vector types and the sweep FSM state encoding for the
// dgldpc variable-node schedule path.
package dgldpc_pkg;

    localparam int unsigned LLR_W  = 9;
    localparam int unsigned MSG_W  = 6;
    localparam int unsigned VOUT_W = 10;
    localparam int unsigned DV     = 4;

    typedef logic [LLR_W-1:0]  llr_t;
    typedef logic [MSG_W-1:0]  msg_t;
    typedef logic [VOUT_W-1:0] vout_t;

    typedef msg_t  [0:DV-1] msg_vec_t;
    // [0:DV-1] extrinsic messages, [DV] a-posteriori value
    typedef vout_t [0:DV]   vout_vec_t;

    typedef enum logic [2:0] {
        StIdle,
        StSweep,
        StDrain,
        StCheck,
        StDone
    } sched_state_e;

endpackage

// File: rtl/vnu_sweep_scheduler_if.sv
// Message-memory and shuffledVNU signal bundle seen from the sweep scheduler.
interface vnu_sweep_scheduler_if
    import dgldpc_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) ();

    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    llr_t              i_rd_llr;
    msg_vec_t          i_rd_msg;
    llr_t              o_vnu_lovnu;
    msg_vec_t          o_vnu_data;
    vout_vec_t         i_vnu_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    vout_vec_t         o_wr_data;
    logic              o_hd;

    modport master (
        output o_rd_en, o_rd_addr, o_vnu_lovnu, o_vnu_data,
        output o_wr_en, o_wr_addr, o_wr_data, o_hd,
        input  i_rd_llr, i_rd_msg, i_vnu_data
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_vnu_lovnu, o_vnu_data,
        input  o_wr_en, o_wr_addr, o_wr_data, o_hd,
        output i_rd_llr, i_rd_msg, i_vnu_data
    );

endinterface

// File: rtl/vnu_sweep_scheduler_pipe.sv
// Three-stage read -> VNU -> write-back delay line: valid/address shift plus
// the VNU input and result registers.
module vnu_sched_pipe
    import dgldpc_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  llr_t              i_rd_llr,
    input  msg_vec_t          i_rd_msg,
    input  vout_vec_t         i_vnu_data,
    output llr_t              o_vnu_lovnu,
    output msg_vec_t          o_vnu_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output vout_vec_t         o_wr_data,
    output logic              o_hd
);

    logic [1:0]        r_vld;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    llr_t              r_vnu_llr;
    msg_vec_t          r_vnu_msg;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    vout_vec_t         r_wr_data;
    logic              r_hd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= '0;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_vnu_llr <= '0;
            r_vnu_msg <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hd      <= 1'b0;
        end else begin
            r_vld   <= {r_vld[0], i_rd_en};
            r_addr1 <= i_rd_addr;
            r_addr2 <= r_addr1;
            // Memory data arrives one cycle after the strobe; VNU inputs hold otherwise
            if (r_vld[0]) begin
                r_vnu_llr <= i_rd_llr;
                r_vnu_msg <= i_rd_msg;
            end
            if (r_vld[1]) begin
                r_wr_data <= i_vnu_data;
                r_hd      <= i_vnu_data[DV][VOUT_W-1];
            end
            r_wr_en   <= r_vld[1];
            r_wr_addr <= r_addr2;
        end
    end

    assign o_vnu_lovnu = r_vnu_llr;
    assign o_vnu_data  = r_vnu_msg;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_hd        = r_hd;

endmodule

// File: rtl/vnu_sweep_scheduler.sv
// Sweep scheduler for the shared shuffledVNU: walks every variable node once per
// iteration, drains the write-back pipeline, then decides whether to iterate again.
module vnu_sweep_scheduler
    import dgldpc_pkg::*;
#(
    parameter int unsigned NUM_VN = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned ITER_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ITER_W-1:0]     i_max_iter,
    input  logic                  i_stop,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ITER_W-1:0]     o_iter_cnt,
    vnu_sweep_scheduler_if.master bus
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_VN - 1);

    sched_state_e      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic [1:0]        r_drain;
    logic [ITER_W-1:0] r_limit;
    logic [ITER_W-1:0] r_iter;
    logic              r_busy;
    logic              r_done;
    logic [ITER_W-1:0] w_iter_next;

    assign w_iter_next = r_iter + ITER_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_drain <= '0;
            r_limit <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_limit <= (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
                        r_iter  <= '0;
                        r_addr  <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StSweep;
                    end
                end
                StSweep: begin
                    if (r_addr == LastAddr) begin
                        r_rd_en <= 1'b0;
                        r_drain <= '0;
                        r_state <= StDrain;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                // Three idle cycles let the last write land before the next sweep reads
                StDrain: begin
                    if (r_drain == 2'd2) begin
                        r_state <= StCheck;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                StCheck: begin
                    r_iter <= w_iter_next;
                    if (i_stop || (w_iter_next == r_limit)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_addr  <= '0;
                        r_rd_en <= 1'b1;
                        r_state <= StSweep;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_iter_cnt    = r_iter;
    assign bus.o_rd_en   = r_rd_en;
    assign bus.o_rd_addr = r_addr;

    vnu_sched_pipe #(
        .ADDR_W(ADDR_W)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (r_rd_en),
        .i_rd_addr  (r_addr),
        .i_rd_llr   (bus.i_rd_llr),
        .i_rd_msg   (bus.i_rd_msg),
        .i_vnu_data (bus.i_vnu_data),
        .o_vnu_lovnu(bus.o_vnu_lovnu),
        .o_vnu_data (bus.o_vnu_data),
        .o_wr_en    (bus.o_wr_en),
        .o_wr_addr  (bus.o_wr_addr),
        .o_wr_data  (bus.o_wr_data),
        .o_hd       (bus.o_hd)
    );

endmodule

// File: doc/vnu_sweep_scheduler.md
Name: vnu_sweep_scheduler

Overview:
- Sequences one shared shuffledVNU across NUM_VN variable nodes for up to a programmable number of decoding iterations in the dgldpc decoder.
- Each cycle it issues a read of one VN's channel LLR and 4 check-to-variable messages from message memory, and registers them into the VNU.
- It captures the 5 VNU outputs and writes them back, with a hard decision.
- Start/busy/done handshake toward the top-level decoder controller; early stop request from the syndrome checker.

Parameters:
- NUM_VN, 64, number of variable nodes per sweep (>=1).
- ADDR_W, 6, memory address width; requires 2**ADDR_W >= NUM_VN.
- ITER_W, 5, iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_start  in  1  start request
- i_max_iter  in  ITER_W  iteration limit, latched on accepted start
- i_stop  in  1  early-termination request
- o_busy  out  1  high in SWEEP/DRAIN/CHECK
- o_done  out  1  single-cycle completion pulse
- o_iter_cnt  out  ITER_W  completed iterations
- o_rd_en  out  1  memory read strobe
- o_rd_addr  out  ADDR_W  read address
- i_rd_llr  in  9  channel LLR, valid 1 cycle after o_rd_en
- i_rd_msg  in  [0:3][5:0]  CN->VN messages, valid 1 cycle after o_rd_en
- o_vnu_lovnu  out  9  registered VNU LLR input
- o_vnu_data  out  [0:3][5:0]  registered VNU message inputs
- i_vnu_data  in  [0:4][9:0]  combinational VNU result; [0:3] extrinsic, [4] APP
- o_wr_en  out  1  write strobe
- o_wr_addr  out  ADDR_W  write address
- o_wr_data  out  [0:4][9:0]  registered VNU result
- o_hd  out  1  hard decision, sign bit (bit 9) of o_wr_data[4]

Behaviour:
- clk is the only clock; rst is synchronous, active-high.
- All outputs are registered. On reset every output is 0, the FSM goes to IDLE and o_iter_cnt is 0. Reset mid-operation drops pending pipeline writes; no o_wr_en follows reset.
- FSM states: IDLE, SWEEP, DRAIN, CHECK, DONE.
- IDLE:
  - i_start=1 latches i_max_iter, with 0 treated as 1.
  - Clears o_iter_cnt and the address counter, then goes to SWEEP.
- SWEEP:
  - One VN per cycle: o_rd_en=1, o_rd_addr = 0..NUM_VN-1.
  - After addr NUM_VN-1 is issued, go to DRAIN.
- Pipeline (read issued in cycle t):
  - t+1: capture i_rd_* into o_vnu_*.
  - t+2: capture i_vnu_data into o_wr_data.
  - t+3: o_wr_en=1, with o_wr_addr equal to the cycle-t address.
  - Write latency is exactly 3 cycles; throughput is 1 VN/cycle.
  - o_vnu_* hold their last value when no read is in flight.
- DRAIN: exactly 3 cycles, no reads. Guarantees the final write of an iteration completes before the first read of the next.
- CHECK (1 cycle):
  - o_iter_cnt increments.
  - If i_stop=1, or the new count equals the latched limit, go to DONE; otherwise go to SWEEP at addr 0.
  - i_stop is sampled only in CHECK and ignored elsewhere.
- DONE (1 cycle): o_done=1, o_busy=0, then go to IDLE. o_iter_cnt holds until the next accepted start.
- Timing:
  - Iteration period is NUM_VN+4 cycles.
  - With start accepted in cycle 0, the first read is in cycle 1.
  - o_done is asserted in cycle K*(NUM_VN+4)+1 for K iterations.
- i_start while not in IDLE (including DONE) is ignored.
- NUM_VN=1 is legal: SWEEP lasts 1 cycle.
- Counter wrap: o_iter_cnt cannot exceed the latched limit, so no wrap occurs.

Decomposition:
- Package dgldpc_pkg:
  - LLR_W=9, MSG_W=6, VOUT_W=10, DV=4.
  - Typedefs llr_t, msg_t, vout_t; msg_vec_t = [0:DV-1] msg_t; vout_vec_t = [0:DV] vout_t.
  - State enum sched_state_e.
- One natural sub-module, vnu_sched_pipe: a 3-stage valid/address delay line plus data registers. The FSM and counters stay in the top module.
- shuffledVNU is instantiated by the parent, not inside this block.

Test Plan:
- NUM_VN=4, i_max_iter=2, i_stop=0, start in cycle 0 -> reads addr 0..3 in cycles 1-4 and 9-12; writes in cycles 4-7 and 12-15; o_done in cycle 17; o_iter_cnt=2.
- i_rd_llr=9'h1F3 and i_rd_msg={6'h01,6'h3F,6'h20,6'h15} at addr 2 -> o_vnu_* equal these one cycle later; o_wr_addr=2 with o_wr_data = model shuffledVNU output 3 cycles after the read; o_hd = bit 9 of the model APP.
- i_max_iter=10 with i_stop=1 held from cycle 0 -> exactly 1 sweep; o_done in cycle NUM_VN+5; o_iter_cnt=1. i_stop pulsed outside CHECK -> no effect.
- i_max_iter=0 -> behaves as 1 iteration. i_start pulsed during SWEEP -> ignored; the transaction count is unchanged.
- rst asserted in cycle 6 of a NUM_VN=4 run -> from the next cycle all outputs are 0, with no further o_wr_en and no o_done. A new start then completes normally.
- NUM_VN=1, i_max_iter=3 -> period 5 cycles; o_done in cycle 16; 3 writes, all to addr 0.
